// File: rtl/arithm_accum.sv
// arithm_accum: frame accumulator placed after the (A+B)*C arithmetic stage.
//
// A ce-gated delay line carries in_valid through the upstream latency. Each
// accepted product is summed into a saturating accumulator. A completed frame
// goes to a one-entry valid/ready output register, and the block keeps sticky
// saturation and drop flags.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   ce         in   clock enable shared with the upstream stage
//   in_valid   in   valid qualifier aligned with upstream operands
//   din        in   IN_W signed product from the upstream stage
//   out_ready  in   consumer ready
//   clr_flags  in   pulse; clears ovf_err / drop_err
//   out_valid  out  frame sum available
//   out_data   out  ACC_W signed frame sum
//   out_sat    out  frame in out_data saturated
//   ovf_err    out  sticky: some frame saturated
//   drop_err   out  sticky: some frame lost to backpressure
//   frame_cnt  out  accepted samples in the current frame
module arithm_accum #(
  parameter int unsigned IN_W      = 29,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned LAT       = 5,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  din,
  input  logic             out_ready,
  input  logic             clr_flags,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic             ovf_err,
  output logic             drop_err,
  output logic [7:0]       frame_cnt
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [7:0]       LAST_IDX = 8'(FRAME_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           r_state, w_state_nxt;
  logic [LAT-1:0]   r_vline, w_vline_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic             r_fsat;
  logic             r_out_valid, r_out_sat, r_ovf, r_drop;
  logic [ACC_W-1:0] r_out_data;

  logic             w_acc_en, w_frame_end, w_clamp, w_slot_free;
  logic [ACC_W:0]   w_sum_wide;
  logic [ACC_W-1:0] w_sum;

  // Valid delay line: one bit per upstream pipeline stage
  generate
    if (LAT == 1) begin : g_vline_1
      assign w_vline_nxt = in_valid;
    end else begin : g_vline_n
      assign w_vline_nxt = {r_vline[LAT-2:0], in_valid};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vline <= '0;
    end else if (ce) begin
      r_vline <= w_vline_nxt;
    end
  end

  assign w_acc_en    = ce & r_vline[LAT-1];
  assign w_slot_free = ~r_out_valid | out_ready;

  // One guard bit: overflow shows up as a disagreement between the top two bits
  assign w_sum_wide = {r_acc[ACC_W-1], r_acc}
                    + {{(ACC_W+1-IN_W){din[IN_W-1]}}, din};

  always_comb begin
    w_clamp = 1'b0;
    w_sum   = w_sum_wide[ACC_W-1:0];
    if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
      w_clamp = 1'b1;
      w_sum   = w_sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Frame FSM: IDLE holds a zero accumulator, RUN is mid-frame
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_frame_end = 1'b0;
    if (w_acc_en) begin
      if ((r_state == S_IDLE) ? (FRAME_LEN == 1) : (r_cnt == LAST_IDX)) begin
        w_frame_end = 1'b1;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_acc_nxt   = '0;
      end else begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = r_cnt + 8'd1;
        w_acc_nxt   = w_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_fsat  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      if (w_acc_en) begin
        r_fsat <= w_frame_end ? 1'b0 : (r_fsat | w_clamp);
      end
    end
  end

  // Output slot: the frame sum loads on the edge that accepts the last sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_frame_end && w_slot_free) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sum;
      r_out_sat   <= r_fsat | w_clamp;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky flags: a new error on the clearing edge takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (w_acc_en && w_clamp) begin
        r_ovf <= 1'b1;
      end else if (clr_flags) begin
        r_ovf <= 1'b0;
      end
      if (w_frame_end && !w_slot_free) begin
        r_drop <= 1'b1;
      end else if (clr_flags) begin
        r_drop <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign ovf_err   = r_ovf;
  assign drop_err  = r_drop;
  assign frame_cnt = r_cnt;

endmodule

// File: tb/tb_arithm_accum.sv
// tb_arithm_accum: directed bench for arithm_accum.
// u_dut uses default parameters; u_sat (ACC_W=30) exercises saturation;
// u_f1 (FRAME_LEN=1) exercises single-sample frames. All share the inputs.
module tb_arithm_accum;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n, ce, in_valid, out_ready, clr_flags;
  logic [28:0] din;

  logic        ov, os, oe, de;
  logic [39:0] od;
  logic [7:0]  fc;
  logic        s_ov, s_os, s_oe, s_de;
  logic [29:0] s_od;
  logic [7:0]  s_fc;
  logic        f_ov, f_os, f_oe, f_de;
  logic [39:0] f_od;
  logic [7:0]  f_fc;

  int checks = 0;
  int errors = 0;

  // Bench-side view of the valid line and pending sample values
  logic [LAT-1:0] m_v;
  logic [28:0]    q[$];
  int             cyc_n;

  int          cap_cnt, cap_cyc, s_cap_cnt, f_cap_cnt;
  logic [39:0] cap_data, f_cap_data;
  logic [29:0] s_cap_data;
  logic        cap_sat, s_cap_sat, s_cap_ovf;

  always #5 clk = ~clk;

  arithm_accum #(.IN_W(29), .ACC_W(40), .LAT(LAT), .FRAME_LEN(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .din(din),
    .out_ready(out_ready), .clr_flags(clr_flags), .out_valid(ov),
    .out_data(od), .out_sat(os), .ovf_err(oe), .drop_err(de), .frame_cnt(fc)
  );

  arithm_accum #(.IN_W(29), .ACC_W(30), .LAT(LAT), .FRAME_LEN(16)) u_sat (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .din(din),
    .out_ready(out_ready), .clr_flags(clr_flags), .out_valid(s_ov),
    .out_data(s_od), .out_sat(s_os), .ovf_err(s_oe), .drop_err(s_de),
    .frame_cnt(s_fc)
  );

  arithm_accum #(.IN_W(29), .ACC_W(40), .LAT(LAT), .FRAME_LEN(1)) u_f1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .din(din),
    .out_ready(out_ready), .clr_flags(clr_flags), .out_valid(f_ov),
    .out_data(f_od), .out_sat(f_os), .ovf_err(f_oe), .drop_err(f_de),
    .frame_cnt(f_fc)
  );

  // One clock: present din for the sample at the tap (garbage otherwise),
  // advance the model, then sample outputs 1 ns after the edge.
  task automatic cyc(input logic iv, input logic cev, input logic [28:0] val);
    ce       = cev;
    in_valid = iv;
    din      = (m_v[LAT-1] && q.size() > 0) ? q[0] : 29'd1000;
    @(posedge clk);
    if (cev) begin
      if (m_v[LAT-1] && q.size() > 0) void'(q.pop_front());
      if (iv) q.push_back(val);
      m_v = {m_v[LAT-2:0], iv};
    end
    #1;
    cyc_n++;
    if (ov) begin
      if (cap_cnt == 0) cap_cyc = cyc_n;
      cap_cnt++;
      cap_data = od;
      cap_sat  = os;
    end
    if (s_ov) begin
      s_cap_cnt++;
      s_cap_data = s_od;
      s_cap_sat  = s_os;
      s_cap_ovf  = s_oe;
    end
    if (f_ov) begin
      f_cap_cnt++;
      f_cap_data = f_od;
    end
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(1'b0, 1'b1, 29'd0);
  endtask

  task automatic clear_caps;
    cap_cnt = 0; cap_cyc = 0; s_cap_cnt = 0; f_cap_cnt = 0;
    cap_data = '0; f_cap_data = '0; s_cap_data = '0;
    cap_sat = 1'b0; s_cap_sat = 1'b0; s_cap_ovf = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ce = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clr_flags = 1'b0; din = '0; m_v = '0; cyc_n = 0;
    #12;
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ov); end
    checks++; if (od !== 40'd0) begin errors++; $display("FAIL reset_data got %0h exp 0", od); end
    checks++; if ({os, oe, de} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {os, oe, de}); end
    checks++; if (fc !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", fc); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int start;
    clear_caps();
    out_ready = 1'b1;
    start = cyc_n;
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b1, 29'd9);
      if (i == LAT + 8) begin
        checks++; if (fc !== 8'd8) begin errors++; $display("FAIL basic_midcnt got %0d exp 8", fc); end
      end
    end
    drain(LAT + 4);
    checks++; if (cap_cnt !== 1) begin errors++; $display("FAIL basic_pulses got %0d exp 1", cap_cnt); end
    checks++; if (cap_cyc - start !== LAT + 16) begin errors++; $display("FAIL basic_latency got %0d exp %0d", cap_cyc - start, LAT + 16); end
    checks++; if (cap_data !== 40'd144) begin errors++; $display("FAIL basic_data got %0d exp 144", cap_data); end
    checks++; if (cap_sat !== 1'b0) begin errors++; $display("FAIL basic_sat got %b exp 0", cap_sat); end
    checks++; if (fc !== 8'd0) begin errors++; $display("FAIL basic_endcnt got %0d exp 0", fc); end
    checks++; if (f_cap_cnt !== 16) begin errors++; $display("FAIL f1_pulses got %0d exp 16", f_cap_cnt); end
    checks++; if (f_cap_data !== 40'd9) begin errors++; $display("FAIL f1_data got %0d exp 9", f_cap_data); end
  endtask

  task automatic test_valid_align;
    logic [28:0] m5;
    m5 = 29'h1FFF_FFFB;
    clear_caps();
    out_ready = 1'b1;
    cyc(1'b1, 1'b1, m5);
    cyc(1'b0, 1'b1, 29'd0);
    cyc(1'b1, 1'b1, m5);
    cyc(1'b1, 1'b1, m5);
    drain(LAT + 1);
    checks++; if (fc !== 8'd3) begin errors++; $display("FAIL align_cnt got %0d exp 3", fc); end
    repeat (13) cyc(1'b1, 1'b1, m5);
    drain(LAT + 3);
    checks++; if (cap_cnt !== 1) begin errors++; $display("FAIL align_pulses got %0d exp 1", cap_cnt); end
    checks++; if (cap_data !== 40'hFF_FFFF_FFB0) begin errors++; $display("FAIL align_data got %0h exp ffffffffb0", cap_data); end
  endtask

  task automatic test_ce_gating;
    int start;
    clear_caps();
    out_ready = 1'b1;
    start = cyc_n;
    repeat (10) cyc(1'b1, 1'b1, 29'd7);
    checks++; if (fc !== 8'd5) begin errors++; $display("FAIL gate_pre_cnt got %0d exp 5", fc); end
    repeat (3) cyc(1'b1, 1'b0, 29'd7);
    checks++; if (fc !== 8'd5) begin errors++; $display("FAIL gate_hold_cnt got %0d exp 5", fc); end
    repeat (6) cyc(1'b1, 1'b1, 29'd7);
    drain(LAT + 4);
    checks++; if (cap_cnt !== 1) begin errors++; $display("FAIL gate_pulses got %0d exp 1", cap_cnt); end
    checks++; if (cap_cyc - start !== LAT + 19) begin errors++; $display("FAIL gate_latency got %0d exp %0d", cap_cyc - start, LAT + 19); end
    checks++; if (cap_data !== 40'd112) begin errors++; $display("FAIL gate_data got %0d exp 112", cap_data); end
  endtask

  task automatic test_saturation;
    clear_caps();
    out_ready = 1'b1;
    clr_flags = 1'b0;
    repeat (16) cyc(1'b1, 1'b1, 29'h0FFF_FFFF);
    drain(LAT + 3);
    checks++; if (s_cap_cnt !== 1) begin errors++; $display("FAIL sat_pulses got %0d exp 1", s_cap_cnt); end
    checks++; if (s_cap_data !== 30'h1FFF_FFFF) begin errors++; $display("FAIL sat_pos_data got %0h exp 1fffffff", s_cap_data); end
    checks++; if (s_cap_sat !== 1'b1) begin errors++; $display("FAIL sat_pos_flag got %b exp 1", s_cap_sat); end
    checks++; if (s_oe !== 1'b1) begin errors++; $display("FAIL sat_ovf_set got %b exp 1", s_oe); end
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL wide_no_ovf got %b exp 0", oe); end
    checks++; if (cap_data !== 40'h00_FFFF_FFF0) begin errors++; $display("FAIL wide_data got %0h exp fffffff0", cap_data); end
    clr_flags = 1'b1;
    cyc(1'b0, 1'b1, 29'd0);
    clr_flags = 1'b0;
    checks++; if (s_oe !== 1'b0) begin errors++; $display("FAIL sat_ovf_clr got %b exp 0", s_oe); end
    clear_caps();
    repeat (16) cyc(1'b1, 1'b1, 29'd1);
    drain(LAT + 3);
    checks++; if (s_cap_data !== 30'd16) begin errors++; $display("FAIL sat_clean_data got %0d exp 16", s_cap_data); end
    checks++; if (s_cap_sat !== 1'b0) begin errors++; $display("FAIL sat_clean_flag got %b exp 0", s_cap_sat); end
    // clr_flags held across a clamping frame: setting must win on clamp edges
    clear_caps();
    clr_flags = 1'b1;
    repeat (16) cyc(1'b1, 1'b1, 29'h1000_0000);
    drain(LAT + 3);
    clr_flags = 1'b0;
    checks++; if (s_cap_data !== 30'h2000_0000) begin errors++; $display("FAIL sat_neg_data got %0h exp 20000000", s_cap_data); end
    checks++; if (s_cap_sat !== 1'b1) begin errors++; $display("FAIL sat_neg_flag got %b exp 1", s_cap_sat); end
    checks++; if (s_cap_ovf !== 1'b1) begin errors++; $display("FAIL sat_set_wins got %b exp 1", s_cap_ovf); end
    checks++; if (s_oe !== 1'b0) begin errors++; $display("FAIL sat_held_clr got %b exp 0", s_oe); end
  endtask

  task automatic test_backpressure;
    int held_bad;
    logic [28:0] v;
    held_bad = 0;
    clr_flags = 1'b1;
    cyc(1'b0, 1'b1, 29'd0);
    clr_flags = 1'b0;
    for (int i = 1; i <= LAT + 50; i++) begin
      out_ready = (i >= LAT + 48);
      v = (i <= 16) ? 29'd1 : (i <= 32) ? 29'd2 : 29'd3;
      cyc(i <= 48, 1'b1, v);
      if (i == LAT + 16) begin
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL bp_first_valid got %b exp 1", ov); end
        checks++; if (od !== 40'd16) begin errors++; $display("FAIL bp_first_data got %0d exp 16", od); end
      end
      if (i > LAT + 16 && i < LAT + 48 && (od !== 40'd16 || ov !== 1'b1)) held_bad++;
      if (i == LAT + 31) begin
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL bp_early_drop got %b exp 0", de); end
      end
      if (i == LAT + 32) begin
        checks++; if (de !== 1'b1) begin errors++; $display("FAIL bp_drop got %b exp 1", de); end
      end
      if (i == LAT + 48) begin
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL bp_reload_valid got %b exp 1", ov); end
        checks++; if (od !== 40'd48) begin errors++; $display("FAIL bp_reload_data got %0d exp 48", od); end
      end
      if (i == LAT + 49) begin
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", ov); end
      end
    end
    checks++; if (held_bad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles exp 0", held_bad); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    repeat (LAT + 7) cyc(1'b1, 1'b1, 29'd1);
    checks++; if (fc !== 8'd7) begin errors++; $display("FAIL rst_pre_cnt got %0d exp 7", fc); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", ov); end
    checks++; if (od !== 40'd0) begin errors++; $display("FAIL rst_mid_data got %0d exp 0", od); end
    checks++; if ({os, oe, de} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags got %b exp 000", {os, oe, de}); end
    checks++; if (fc !== 8'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", fc); end
    m_v = '0;
    q.delete();
    #2 rst_n = 1'b1;
    clear_caps();
    repeat (16) cyc(1'b1, 1'b1, 29'd1);
    drain(LAT + 3);
    checks++; if (cap_cnt !== 1) begin errors++; $display("FAIL rst_after_pulses got %0d exp 1", cap_cnt); end
    checks++; if (cap_data !== 40'd16) begin errors++; $display("FAIL rst_after_data got %0d exp 16", cap_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_valid_align();
    test_ce_gating();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/arithm_accum.md
Name: arithm_accum

Overview:
- Downstream consumer of the (A+B)*C arithmetic stage.
- Tracks sample validity through the upstream pipeline latency with a ce-gated valid delay line.
- Accumulates FRAME_LEN signed 29-bit products into a saturating ACC_W-bit sum.
- Presents each frame sum on a one-entry valid/ready output register, with sticky overflow and drop flags.

Parameters:
- IN_W, 29: width of signed product input din.
- ACC_W, 40: accumulator and out_data width; must be at least IN_W+1.
- LAT, 5: upstream pipeline latency in ce-enabled cycles; depth of the valid delay line.
- FRAME_LEN, 16: accepted samples per frame; range 1 to 255.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- ce, in, 1: clock enable shared with the upstream stage.
- in_valid, in, 1: valid qualifier aligned with the upstream A/B/C operands.
- din, in, IN_W: signed product from the upstream stage (O).
- out_ready, in, 1: consumer ready.
- clr_flags, in, 1: one-cycle pulse; clears the sticky flags.
- out_valid, out, 1: frame sum available.
- out_data, out, ACC_W: signed frame sum.
- out_sat, out, 1: the frame in out_data saturated.
- ovf_err, out, 1: sticky; some frame saturated.
- drop_err, out, 1: sticky; some frame was lost to backpressure.
- frame_cnt, out, 8: accepted samples in the current frame.

Behaviour:
- Reset (async assert, sync-safe deassert): valid line, accumulator, frame_cnt, out_valid, out_data, out_sat, ovf_err and drop_err all 0. A reset mid-frame discards the partial sum.
- Valid line: LAT-deep shift register of in_valid.
  - Shifts only when ce=1.
  - Tap vtap = stage LAT-1.
- Accept condition: acc_en = ce & vtap. din is sampled only when acc_en=1; otherwise din is ignored.
- Arithmetic: sum = acc + sign_extend(din, ACC_W), computed in ACC_W+1 bits.
  - If the result exceeds 2^(ACC_W-1)-1, clamp to that value.
  - If the result is below -2^(ACC_W-1), clamp to that value.
  - On clamp, set frame_sat and ovf_err.
  - frame_sat is an internal per-frame flag, cleared at frame end.
- FSM, 2 states:
  - IDLE: frame_cnt=0, acc=0. acc_en -> RUN; acc=sum; frame_cnt=1.
  - RUN: acc_en with frame_cnt<FRAME_LEN-1 -> acc=sum, frame_cnt+1.
  - RUN: acc_en with frame_cnt=FRAME_LEN-1 is a frame end -> IDLE; acc=0; frame_cnt=0.
  - FRAME_LEN=1: every acc_en is a frame end, taken directly from IDLE.
- ce=0: FSM, valid line and accumulator all hold. The output handshake still operates.
- Output register (slot): free when out_valid=0 or out_ready=1.
  - At frame end with slot free: out_data=final sum, out_sat=frame_sat, out_valid=1. These appear on the same edge that accepts the last sample (zero added latency).
  - At frame end with slot not free: frame discarded, drop_err=1, out_data/out_sat unchanged. Accumulator still clears.
- Drain without a new frame end: out_valid & out_ready -> out_valid=0 next edge.
- Drain and frame end on the same edge: the new frame loads; out_valid stays 1.
- Stability: out_data and out_sat are stable while out_valid & !out_ready.
- clr_flags: clears ovf_err/drop_err next edge. If a new error occurs on the same edge, set wins.
- No combinational path from any input to any output.

Test Plan:
- Basic frame: FRAME_LEN=16, ce=1, in_valid high 16 cycles, din=9 at each vtap, out_ready=1.
  - out_valid pulses 1 cycle with out_data=144, out_sat=0.
  - Pulse occurs LAT+15 edges after the first in_valid.
- Valid alignment: in_valid pattern 1,0,1,1 with din=-5 only when vtap=1 and din=1000 otherwise.
  - frame_cnt counts 3; garbage din values are not accumulated.
- ce gating: mid-frame drop ce for 3 cycles while in_valid=1.
  - frame_cnt and acc frozen; in-flight valid bits remain.
  - Frame completes 3 cycles later; sum identical to the ungated run.
- Saturation: ACC_W=30, din=2^28-1 for 16 samples.
  - out_data=2^29-1, out_sat=1, ovf_err=1.
  - clr_flags pulse -> ovf_err=0.
  - Next clean frame has out_sat=0.
- Backpressure: out_ready=0, two frames of din=1 and din=2.
  - out_data=16 held; second frame dropped; drop_err=1.
  - Raise out_ready on the third frame end edge: out_data=48 (din=3), out_valid stays 1.
- Reset mid-frame: assert rst_n=0 after 7 samples, asynchronously between edges.
  - All outputs 0 immediately.
  - After release, 16 samples of din=1 -> out_data=16.
